// File: rtl/f_pkg.sv
// rtl/f_pkg.sv - shared widths, constants and state codes for the float normalize/round stage
package f_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 28;
  localparam int BIAS   = 127;

  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // out_flags bit positions: {overflow, underflow, inexact}
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/f_norm_round_if.sv
// rtl/f_norm_round_if.sv - sum-in / packed-result-out handshake bundle
interface f_norm_round_if;
  import f_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              in_nan;
  logic              in_inf;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out;
  logic [2:0]        out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
    input  in_ready, out_valid, out, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
    output in_ready, out_valid, out, out_flags
  );

endinterface

// File: rtl/f_round_rne.sv
// rtl/f_round_rne.sv - combinational round-to-nearest-even on a 23-bit fraction
module f_round_rne
  import f_pkg::*;
(
  input  logic              hidden,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  input  logic signed [9:0] exp_in,
  output logic [FRAC_W-1:0] frac_out,
  output logic signed [9:0] exp_out,
  output logic              inexact,
  output logic              carry
);

  logic          inc;
  logic [FRAC_W:0] frac_sum;

  // Carry out of the fraction only bumps the exponent when the hidden bit was
  // already set; a subnormal carrying into the hidden bit stays at exponent 1.
  always_comb begin
    inc      = g & (r | s | frac_in[0]);
    frac_sum = {1'b0, frac_in} + {{FRAC_W{1'b0}}, inc};
    carry    = frac_sum[FRAC_W];
    frac_out = carry ? '0 : frac_sum[FRAC_W-1:0];
    exp_out  = (carry & hidden) ? exp_in + 10'sd1 : exp_in;
    inexact  = g | r | s;
  end

endmodule

// File: rtl/f_norm_round.sv
// rtl/f_norm_round.sv - sequential normalize and round-to-nearest-even to IEEE-754 single
module f_norm_round
  import f_pkg::*;
#(
  parameter bit FTZ = 1'b0
) (
  input logic            clk,
  input logic            rstn,
  f_norm_round_if.slave  bus
);

  localparam logic signed [9:0] EXP_LIM = 10'(EXP_MAX);

  logic [1:0]        state_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [MANT_W-1:0] mant_q;
  logic [31:0]       out_q;
  logic [2:0]        flags_q;

  logic [MANT_W-1:0] mant_sh;
  logic signed [9:0] in_exp_s;
  logic [FRAC_W-1:0] rnd_frac;
  logic signed [9:0] rnd_exp;
  logic              rnd_inexact;
  logic              rnd_carry;
  logic              hid_after;
  logic [31:0]       res_out;
  logic [2:0]        res_flags;

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = out_q;
  assign bus.out_flags = flags_q;

  assign in_exp_s = signed'({2'b00, bus.in_exp});

  // Bit 0 carries sticky and must not move; zero enters at the round position
  assign mant_sh = {mant_q[MANT_W-2:1], 1'b0, mant_q[0]};

  f_round_rne u_round (
    .hidden   (mant_q[MANT_W-2]),
    .frac_in  (mant_q[MANT_W-3:3]),
    .g        (mant_q[2]),
    .r        (mant_q[1]),
    .s        (mant_q[0]),
    .exp_in   (exp_q),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .inexact  (rnd_inexact),
    .carry    (rnd_carry)
  );

  assign hid_after = mant_q[MANT_W-2] | rnd_carry;

  // Pack the rounded value, classifying overflow / subnormal / normal
  always_comb begin
    res_out             = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
    res_flags           = 3'b000;
    res_flags[FLAG_INX] = rnd_inexact;
    if (rnd_exp >= EXP_LIM) begin
      res_out             = {sign_q, 8'hFF, {FRAC_W{1'b0}}};
      res_flags[FLAG_OVF] = 1'b1;
      res_flags[FLAG_INX] = 1'b1;
    end else if (!hid_after) begin
      if (FTZ) begin
        res_out             = {sign_q, 31'b0};
        res_flags[FLAG_UNF] = 1'b1;
        res_flags[FLAG_INX] = 1'b1;
      end else begin
        res_out             = {sign_q, 8'h00, rnd_frac};
        res_flags[FLAG_UNF] = rnd_inexact;
      end
    end
  end

  // Control FSM: capture the sum, normalize one bit per cycle, round, hold result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sign_q  <= bus.in_sign;
            flags_q <= '0;
            if (bus.in_nan) begin
              out_q   <= QNAN;
              state_q <= ST_DONE;
            end else if (bus.in_inf) begin
              out_q   <= {bus.in_sign, 8'hFF, {FRAC_W{1'b0}}};
              state_q <= ST_DONE;
            end else if (bus.in_mant == '0) begin
              out_q   <= {bus.in_sign, 31'b0};
              state_q <= ST_DONE;
            end else if (bus.in_mant[MANT_W-1]) begin
              mant_q  <= {1'b0, bus.in_mant[MANT_W-1:2], bus.in_mant[1] | bus.in_mant[0]};
              exp_q   <= in_exp_s + 10'sd1;
              state_q <= ST_ROUND;
            end else begin
              mant_q  <= bus.in_mant;
              exp_q   <= in_exp_s;
              // Already normalized, or already at the subnormal floor: no shifting
              state_q <= (bus.in_mant[MANT_W-2] || bus.in_exp == 8'd1) ? ST_ROUND : ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          mant_q <= mant_sh;
          exp_q  <= exp_q - 10'sd1;
          if (mant_sh[MANT_W-2] || exp_q == 10'sd2) begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          out_q   <= res_out;
          flags_q <= res_flags;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
